// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the 7-segment display scanner.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  // Counter width large enough to hold the longer of the two slot lengths.
  function automatic int cnt_width(input int show, input int blank);
    int m;
    m = (show > blank) ? show : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Loadable down-counter that times BLANK and SHOW slots.
// done_o is high while the count sits at zero; the count holds at zero.
module sevenseg_scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scanner for a DIGITS-wide 7-segment display.
// Digits are shadowed at frame boundaries so a frame never mixes old and new values.
// Optional build macro: SEVENSEG_SCAN_LZB_EN enables leading-zero blanking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   digits_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  output logic [3:0]            bin_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_sel_o,
  output logic [DIGITS-1:0]     digit_seln_o,
  output logic                  blank_o,
  output logic                  frame_done_o
);

  localparam int CW   = cnt_width(SHOW_CYC, BLANK_CYC);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  scan_state_t               state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  nibble_t [DIGITS-1:0]      shadow_q, shadow_d;
  logic [DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
  logic                      pending_q, pending_d;

  logic                      tmr_load;
  logic [CW-1:0]             tmr_val;
  logic [CW-1:0]             tmr_cnt;
  logic                      tmr_done;
  logic                      boundary;
  logic                      take;

  logic                      lit_d;
  logic                      lzb_dark;
  logic [3:0]                bin_d;
  logic                      dp_d;
  logic [DIGITS-1:0]         sel_d;
  logic                      fd_d;

  sevenseg_scan_timer #(.CW(CW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .done_o     (tmr_done)
  );

  // Scan FSM: next state, digit index and timer reloads; boundary marks frame start.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    boundary = 1'b0;
    if (!en_i) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_BLANK;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = CW'(BLANK_CYC - 1);
          boundary = 1'b1;
        end
        S_BLANK: begin
          if (tmr_done) begin
            state_d  = S_SHOW;
            tmr_load = 1'b1;
            tmr_val  = CW'(SHOW_CYC - 1);
          end
        end
        S_SHOW: begin
          if (tmr_done) begin
            state_d  = S_BLANK;
            tmr_load = 1'b1;
            tmr_val  = CW'(BLANK_CYC - 1);
            if (idx_q == LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d    = idx_q + IW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shadow copy only at a frame boundary, and only if a load is pending or arriving now.
  always_comb begin
    take        = boundary && (pending_q || load_i);
    shadow_d    = take ? digits_i : shadow_q;
    shadow_dp_d = take ? dp_in_i  : shadow_dp_q;
    pending_d   = take ? 1'b0     : (pending_q || load_i);
  end

`ifdef SEVENSEG_SCAN_LZB_EN
  logic [DIGITS-1:0] zero_from;

  // zero_from[k]: shadow digits k..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (shadow_d[DIGITS-1] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--)
      zero_from[k] = zero_from[k+1] && (shadow_d[k] == 4'h0);
  end

  assign lzb_dark = (idx_d != '0) && zero_from[idx_d];
`else
  assign lzb_dark = 1'b0;
`endif

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    lit_d = (state_d == S_SHOW) && !lzb_dark;
    sel_d = lit_d ? (DIGITS'(1) << idx_d) : '0;
    bin_d = lit_d ? shadow_d[idx_d] : 4'h0;
    dp_d  = lit_d && shadow_dp_d[idx_d];
    // Final SHOW cycle of the last digit: entering a 1-cycle slot, or count about to hit 0.
    fd_d  = (state_d == S_SHOW) && (idx_d == LAST) &&
            ((state_q == S_SHOW) ? (tmr_cnt == CW'(1)) : (SHOW_CYC == 1));
  end

  // State, shadow and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      bin_o        <= 4'h0;
      dp_o         <= 1'b0;
      digit_sel_o  <= '0;
      digit_seln_o <= '1;
      blank_o      <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      bin_o        <= bin_d;
      dp_o         <= dp_d;
      digit_sel_o  <= sel_d;
      digit_seln_o <= ~sel_d;
      blank_o      <= !lit_d;
      frame_done_o <= fd_d;
    end
  end

endmodule
